// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: queue entry layout, slot
// validity encoding and the two-slot decode interface.
package inst_fetch_queue_pkg;

    typedef enum logic {
        INVALID = 1'b0,
        VALID   = 1'b1
    } control_signal_t;

    // IDLE: no fetch response due next cycle; WAIT: one response is due.
    typedef enum logic {
        FQ_IDLE = 1'b0,
        FQ_WAIT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    typedef struct packed {
        control_signal_t is_valid;
        logic [31:0]     pc;
        logic [31:0]     instr;
    } inst_slot_t;

    typedef struct packed {
        inst_slot_t a;
        inst_slot_t b;
    } Inst_PC_N;

    localparam logic [31:0] FETCH_STRIDE = 32'd8;
    localparam logic [31:0] WORD_BYTES   = 32'd4;

    function automatic logic [1:0] clamp_pop(input logic [1:0] req);
        return (req == 2'd3) ? 2'd2 : req;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// DEPTH x 64 entry store for the fetch queue: two write ports (tail, tail+1)
// and two combinational read ports (head, head+1).
module fq_ram
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr_a,
    input  logic [AW-1:0] i_waddr_b,
    input  fq_entry_t     i_wdata_a,
    input  fq_entry_t     i_wdata_b,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    output fq_entry_t     o_rdata_a,
    output fq_entry_t     o_rdata_b
);

    fq_entry_t w_entries [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        fq_entry_t r_entry;

        // The two write addresses are always distinct, so port order is moot.
        always_ff @(posedge clk) begin
            if (i_we && (i_waddr_a == AW'(gi))) begin
                r_entry <= i_wdata_a;
            end else if (i_we && (i_waddr_b == AW'(gi))) begin
                r_entry <= i_wdata_b;
            end
        end

        assign w_entries[gi] = r_entry;
    end

    assign o_rdata_a = w_entries[i_raddr_a];
    assign o_rdata_b = w_entries[i_raddr_b];

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-issue fetch front end: PC generation, credit-gated two-word fetch,
// circular queue of {pc, instr} and a two-slot view of its oldest entries.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [31:0]             imem_addr,
    input  logic [31:0]             imem_rdata_a,
    input  logic [31:0]             imem_rdata_b,
    input  logic                    flush,
    input  logic [31:0]             flush_pc,
    input  logic [1:0]              pop_cnt,
    output Inst_PC_N                inst_out,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] PUSH_LIMIT = CW'(DEPTH - 2);

    logic [31:0]   r_pc,      w_pc_next;
    logic [31:0]   r_req_pc,  w_req_pc_next;
    fetch_state_t  r_state,   w_state_next;
    logic [AW-1:0] r_head,    w_head_next;
    logic [AW-1:0] r_tail,    w_tail_next;
    logic [CW-1:0] r_count,   w_count_next;

    logic          w_pending;
    logic [CW:0]   w_credit_need;
    logic          w_req;
    logic          w_push;
    logic [1:0]    w_pop_req;
    logic [1:0]    w_pop;
    fq_entry_t     w_wdata_a, w_wdata_b, w_rdata_a, w_rdata_b;

    // Credit counts the response already in flight, so an issued request
    // always finds two free slots even if decode pops nothing meanwhile.
    assign w_pending     = (r_state == FQ_WAIT);
    assign w_credit_need = {1'b0, r_count} + (w_pending ? (CW+1)'(2) : '0);
    assign w_req         = !rst && !flush && (w_credit_need <= {1'b0, PUSH_LIMIT});
    assign w_push        = w_pending && !flush;
    assign w_pop_req     = clamp_pop(pop_cnt);
    assign w_pop         = (r_count < CW'(w_pop_req)) ? r_count[1:0] : w_pop_req;

    always_comb begin
        w_pc_next     = r_pc;
        w_req_pc_next = r_req_pc;
        w_state_next  = r_state;
        w_head_next   = r_head;
        w_tail_next   = r_tail;
        w_count_next  = r_count;
        if (flush) begin
            w_pc_next    = flush_pc;
            w_state_next = FQ_IDLE;
            w_head_next  = '0;
            w_tail_next  = '0;
            w_count_next = '0;
        end else begin
            w_state_next = w_req ? FQ_WAIT : FQ_IDLE;
            if (w_req) begin
                w_pc_next     = r_pc + FETCH_STRIDE;
                w_req_pc_next = r_pc;
            end
            if (w_push) begin
                w_tail_next = r_tail + AW'(2);
            end
            w_head_next  = r_head + AW'(w_pop);
            w_count_next = r_count + (w_push ? CW'(2) : '0) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_state  <= FQ_IDLE;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
        end else begin
            r_pc     <= w_pc_next;
            r_req_pc <= w_req_pc_next;
            r_state  <= w_state_next;
            r_head   <= w_head_next;
            r_tail   <= w_tail_next;
            r_count  <= w_count_next;
        end
    end

    assign w_wdata_a = '{pc: r_req_pc,              instr: imem_rdata_a};
    assign w_wdata_b = '{pc: r_req_pc + WORD_BYTES, instr: imem_rdata_b};

    fq_ram #(.DEPTH(DEPTH)) u_ram (
        .clk       (clk),
        .i_we      (w_push),
        .i_waddr_a (r_tail),
        .i_waddr_b (r_tail + AW'(1)),
        .i_wdata_a (w_wdata_a),
        .i_wdata_b (w_wdata_b),
        .i_raddr_a (r_head),
        .i_raddr_b (r_head + AW'(1)),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b)
    );

    always_comb begin
        inst_out            = '0;
        inst_out.a.is_valid = INVALID;
        inst_out.b.is_valid = INVALID;
        if (r_count >= CW'(1)) begin
            inst_out.a.is_valid = VALID;
            inst_out.a.pc       = w_rdata_a.pc;
            inst_out.a.instr    = w_rdata_a.instr;
        end
        if (r_count >= CW'(2)) begin
            inst_out.b.is_valid = VALID;
            inst_out.b.pc       = w_rdata_b.pc;
            inst_out.b.instr    = w_rdata_b.instr;
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign count     = r_count;
    assign empty     = (r_count == '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        w_push |-> ((r_count - CW'(w_pop)) <= PUSH_LIMIT));

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Front end of the dual-issue pipeline: generates the fetch PC, requests two instruction words per cycle from synchronous instruction memory, and buffers them in a circular queue.
- Presents the two oldest entries to decode as an Inst_PC_N (slot A = oldest, slot B = next).
- Decode consumes 0, 1 or 2 entries per cycle.
- A flush from branch/jump resolution redirects the PC and discards queued and in-flight instructions.

Parameters:
- DEPTH, 8, queue entries (power of 2, >= 4).
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  32  word-aligned fetch PC; memory returns words at imem_addr and imem_addr+4
- imem_rdata_a  in  32  word at requested PC, valid the cycle after imem_req
- imem_rdata_b  in  32  word at requested PC+4, same timing
- flush  in  1  redirect request
- flush_pc  in  32  redirect target (word-aligned)
- pop_cnt  in  2  entries decode consumes this cycle (0, 1, 2; 3 treated as 2)
- inst_out  out  Inst_PC_N  slot A = head, slot B = head+1; is_valid = VALID if occupied, else INVALID, with pc/instr = 0
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

Behaviour:
- Reset (async, immediate):
  - pc_reg = RESET_PC; imem_req = 0; resp_pending = 0.
  - head = tail = count = 0; empty = 1; both inst_out slots INVALID/zero.
- Request rule: imem_req = !flush && (count + 2*resp_pending) <= DEPTH-2.
  - Decision uses registered count only; same-cycle pops are ignored (conservative credit).
  - imem_addr = pc_reg. On request, pc_reg += 8 (wraps mod 2^32).
  - resp_pending <= imem_req.
- Response: when resp_pending = 1 and no flush, push {pc_of_req, rdata_a} at tail and {pc_of_req+4, rdata_b} at tail+1. tail += 2 mod DEPTH.
  - pc_of_req is a register capturing imem_addr at request time.
  - Overflow is impossible under the credit rule; an assertion checks it.
- Pop: effective pop = min(pop_cnt clamped to 2, count). head += effective pop mod DEPTH.
- Simultaneous push and pop in one cycle: count_next = count + push(0|2) - pop. Entries pushed this cycle are not visible on inst_out until the next cycle.
- inst_out is combinational from registered head/count:
  - A valid iff count >= 1.
  - B valid iff count >= 2.
- Flush (highest priority, registered):
  - Next cycle: count = 0, head = tail = 0, resp_pending = 0, pc_reg = flush_pc.
  - Any response arriving in the flush cycle or the cycle after is discarded; the flush-cycle request is suppressed, so the discard case cannot occur.
  - pop_cnt is ignored in the flush cycle.
  - First post-flush request (imem_addr = flush_pc) issues in the cycle after flush.
- Latency: redirect/reset to first valid inst_out = 2 cycles (request, response/push, visible next edge).
- Steady state with pop_cnt = 2 every cycle: 2 instructions per cycle after the 2-cycle fill.
- Wrap-around: head and tail index mod DEPTH; count distinguishes full from empty.
- No FSM beyond the resp_pending bit. States: IDLE (no pending), WAIT (pending). A flush or a failed credit check moves the block to IDLE.

Decomposition:
- Shared package (struct_helpers): add typedef fq_entry_t {pc[31:0], instr[31:0]}.
- enum_helpers: control_signal_t must provide VALID/INVALID.
- One natural sub-module: fq_ram, a DEPTH x 64 two-write / two-read register array. It has:
  - dual write ports at tail/tail+1;
  - combinational read ports at head/head+1.
- Credit/pointer logic stays in the top.

Test Plan:
- Reset, RESET_PC=0, pop_cnt=0 → imem_addr 0, 8, 16 in successive cycles. Requests stop at count=8 with no overflow. inst_out A = {pc 0, instr mem[0]}, B = {pc 4, mem[1]}.
- pop_cnt=2 every cycle from reset → cycle 2 onward shows A/B pc pairs 0/4, 8/12, 16/20, … with no bubbles. count stays at 2.
- Queue at count=1 with pop_cnt=2 and no response → only A consumed. count=0, empty=1, both slots INVALID.
- flush=1, flush_pc=32'h100 while count=6 and a response is pending → next cycle count=0 and empty; the pending response is discarded. Then imem_addr=0x100, and A.pc=0x100, B.pc=0x104 appear 2 cycles later.
- Wrap: DEPTH=8, alternate push 2 / pop 1 past index 7 → pc order stays monotonic by 4 across head/tail wrap. count never exceeds 8.
- rst asserted mid-stream (count=5, response pending) → outputs reset asynchronously in the same cycle. After release, fetch restarts at RESET_PC with no stale entries.
